// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction prefetch queue.
package fetch_queue_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch over a req/ack memory into a
// small FIFO of {inst, pc+4}; redirects flush the queue and restart fetch.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_ack,
  input  logic [XLEN-1:0]        imem_rdata,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   stall,
  output logic                   inst_valid,
  output logic [XLEN-1:0]        inst,
  output logic [XLEN-1:0]        inst_pc4,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              req_d;
  logic [XLEN-1:0]   addr_d;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  cnt_after;
  logic              push, pop, space;
  fq_entry_t         fifo_q [DEPTH];

  // Redirect outranks both FIFO ports; a killed request never pushes.
  always_comb begin
    push      = (state_q == REQ) && imem_ack && !redirect;
    pop       = inst_valid && !stall && !redirect;
    cnt_after = count + CNT_W'(push) - CNT_W'(pop);
    space     = cnt_after < CNT_W'(DEPTH);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = 1'b0;
    addr_d     = '0;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      state_d    = (state_q != IDLE && !imem_ack) ? DROP : IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (space) state_d = REQ;
        REQ: begin
          if (imem_ack) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = space ? REQ : IDLE;
          end
        end
        DROP: if (imem_ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // In DROP the bus keeps showing the killed request's address.
    unique case (state_d)
      REQ: begin
        req_d  = 1'b1;
        addr_d = fetch_pc_d;
      end
      DROP: begin
        req_d  = 1'b1;
        addr_d = imem_addr;
      end
      default: begin
        req_d  = 1'b0;
        addr_d = '0;
      end
    endcase
  end

  // Fetch FSM and bus output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      imem_req   <= req_d;
      imem_addr  <= addr_d;
    end
  end

  // FIFO pointers, occupancy and head-valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inst_valid <= 1'b0;
    end else if (redirect) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      inst_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= cnt_after;
      inst_valid <= (cnt_after != '0);
    end
  end

  // Entry storage needs no reset; the head is gated by inst_valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{inst: imem_rdata, pc4: fetch_pc_q + XLEN'(4)};
  end

  always_comb begin
    inst     = inst_valid ? fifo_q[rd_ptr].inst : '0;
    inst_pc4 = inst_valid ? fifo_q[rd_ptr].pc4  : '0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } m_ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          stall = 1'b0;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [31:0]   inst_pc4;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .inst_pc4(inst_pc4),
    .count(count)
  );

  int n_checks = 0;
  int n_err    = 0;

  // memory / stimulus knobs
  int lat        = 0;
  int w          = 0;
  int stall_mode = 0;
  int spur_pct   = 0;

  // reference model: outstanding request, killed flag, queue of entries
  bit          m_out, m_kill;
  logic [31:0] m_addr, m_pc;
  m_ent_t      mq[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_kill = 0; m_addr = '0; m_pc = 32'h0;
    mq.delete();
  endtask

  task automatic model_step(input logic ack, input logic [31:0] rdata,
                            input logic redir, input logic [31:0] rpc, input logic stl);
    bit was_idle, done, pop, push;
    was_idle = !m_out;
    done     = m_out && ack;
    pop      = (mq.size() != 0) && !stl && !redir;
    push     = done && !m_kill && !redir;
    if (redir) begin
      mq.delete();
      m_pc = rpc;
      if (done) begin m_out = 0; m_kill = 0; end
      else if (m_out) m_kill = 1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{inst: rdata, pc4: m_addr + 32'd4});
        m_pc = m_addr + 32'd4;
      end
      if (done) begin m_out = 0; m_kill = 0; end
      if ((was_idle || push) && mq.size() < int'(DEPTH)) begin
        m_out  = 1;
        m_addr = m_pc;
      end
    end
  endtask

  task automatic check_model();
    chk("req", 32'(imem_req), 32'(m_out));
    chk("addr", imem_addr, m_out ? m_addr : 32'h0);
    chk("valid", 32'(inst_valid), 32'(mq.size() != 0));
    chk("inst", inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
    chk("pc4", inst_pc4, (mq.size() != 0) ? mq[0].pc4 : 32'h0);
    chk("count", 32'(count), 32'(mq.size()));
  endtask

  // Memory behaviour for the current cycle: ack after `lat` wait cycles.
  task automatic mem_respond();
    if (imem_req) begin
      if (w >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        w = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        w++;
      end
    end else begin
      w = 0;
      imem_ack   = (int'($urandom_range(99)) < spur_pct);
      imem_rdata = $urandom;
    end
  endtask

  task automatic commit(input logic redir, input logic [31:0] rpc);
    redirect    = redir;
    redirect_pc = rpc;
    case (stall_mode)
      0:       stall = 1'b0;
      1:       stall = 1'b1;
      default: stall = 1'($urandom_range(1));
    endcase
    model_step(imem_ack, imem_rdata, redir, rpc, stall);
    @(posedge clk);
    #1;
    check_model();
    redirect = 1'b0;
  endtask

  task automatic cyc();
    mem_respond();
    commit(1'b0, 32'h0);
  endtask

  task automatic apply_reset();
    imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    w = 0;
    #2;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc4", inst_pc4, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    logic        rdir;

    // 1: streaming with a single-cycle memory
    apply_reset();
    lat = 0; stall_mode = 0; spur_pct = 0;
    cyc();
    chk("t1_first_req", 32'(imem_req), 32'h1);
    chk("t1_first_addr", imem_addr, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("t1_addr", imem_addr, 32'(4 * k));
      chk("t1_pc4", inst_pc4, 32'(4 * k));
      chk("t1_valid", 32'(inst_valid), 32'h1);
    end

    // 2: fill under stall, then drain
    apply_reset();
    stall_mode = 1;
    repeat (5) cyc();
    chk("t2_full_count", 32'(count), 32'd4);
    chk("t2_full_req", 32'(imem_req), 32'h0);
    cyc();
    chk("t2_idle_req", 32'(imem_req), 32'h0);
    chk("t2_head", inst_pc4, 32'd4);
    stall_mode = 0;
    cyc();
    chk("t2_resume_addr", imem_addr, 32'd16);
    chk("t2_pop1", inst_pc4, 32'd8);
    cyc();
    chk("t2_pop2", inst_pc4, 32'd12);
    cyc();
    chk("t2_pop3", inst_pc4, 32'd16);
    cyc();
    chk("t2_pop4", inst_pc4, 32'd20);

    // 3: redirect while full
    apply_reset();
    stall_mode = 1;
    repeat (5) cyc();
    mem_respond();
    commit(1'b1, 32'h100);
    chk("t3_count", 32'(count), 32'h0);
    cyc();
    chk("t3_addr", imem_addr, 32'h100);
    cyc();
    chk("t3_pc4", inst_pc4, 32'h104);

    // 4: redirect against a slow outstanding request
    apply_reset();
    stall_mode = 0; lat = 3;
    mem_respond();
    commit(1'b1, 32'h20);
    cyc();
    chk("t4_req_addr", imem_addr, 32'h20);
    mem_respond();
    commit(1'b1, 32'h200);
    chk("t4_drop_addr", imem_addr, 32'h20);
    chk("t4_drop_req", 32'(imem_req), 32'h1);
    repeat (2) begin
      cyc();
      chk("t4_hold", imem_addr, 32'h20);
    end
    cyc();
    chk("t4_after_ack_req", 32'(imem_req), 32'h0);
    chk("t4_no_push", 32'(count), 32'h0);
    cyc();
    chk("t4_new_addr", imem_addr, 32'h200);

    // 5: redirect coincident with ack
    apply_reset();
    stall_mode = 1; lat = 0;
    mem_respond();
    commit(1'b1, 32'h38);
    repeat (3) cyc();
    chk("t5_pre_addr", imem_addr, 32'h40);
    chk("t5_pre_count", 32'(count), 32'd2);
    lat = 1;
    cyc();
    mem_respond();
    commit(1'b1, 32'h300);
    chk("t5_count", 32'(count), 32'h0);
    chk("t5_valid", 32'(inst_valid), 32'h0);
    cyc();
    chk("t5_addr", imem_addr, 32'h300);

    // 6: reset mid-request, then address wrap
    apply_reset();
    stall_mode = 0; lat = 2;
    repeat (2) cyc();
    chk("t6_busy", 32'(imem_req), 32'h1);
    rst = 1'b0;
    model_reset();
    w = 0;
    #2;
    chk("t6_async_req", 32'(imem_req), 32'h0);
    chk("t6_async_addr", imem_addr, 32'h0);
    check_model();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();
    chk("t6_restart", imem_addr, 32'h0);
    lat = 0;
    mem_respond();
    commit(1'b1, 32'hFFFF_FFFC);
    cyc();
    chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("t6_wrap_addr", imem_addr, 32'h0);
    chk("t6_wrap_pc4", inst_pc4, 32'h0);
    chk("t6_wrap_valid", 32'(inst_valid), 32'h1);

    // randomized traffic against the model
    apply_reset();
    stall_mode = 2; spur_pct = 5;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) lat = int'($urandom_range(3));
      if (i == 2000) apply_reset();
      mem_respond();
      rdir = ($urandom_range(15) == 0);
      rpc  = $urandom;
      if ($urandom_range(7) == 0) rpc = 32'hFFFF_FFF0;
      rpc[1:0] = 2'b00;
      commit(rdir, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
